// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between two cache controllers, the port arbiter and main memory
interface mem_port_arbiter_if;
  logic         p0_read_req;
  logic         p0_write_req;
  logic [31:0]  p0_addr;
  logic [31:0]  p0_data_out;
  logic [511:0] p0_data_in;
  logic         p0_ready;
  logic         p0_err;

  logic         p1_read_req;
  logic         p1_write_req;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_data_out;
  logic [511:0] p1_data_in;
  logic         p1_ready;
  logic         p1_err;

  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;

  logic         busy;
  logic         grant_id;

  // slave is the arbiter's view; master is the surrounding requesters and memory
  modport slave (
    input  p0_read_req, p0_write_req, p0_addr, p0_data_out,
    output p0_data_in, p0_ready, p0_err,
    input  p1_read_req, p1_write_req, p1_addr, p1_data_out,
    output p1_data_in, p1_ready, p1_err,
    output main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
    input  main_mem_data_in, main_mem_ready,
    output busy, grant_id
  );

  modport master (
    output p0_read_req, p0_write_req, p0_addr, p0_data_out,
    input  p0_data_in, p0_ready, p0_err,
    output p1_read_req, p1_write_req, p1_addr, p1_data_out,
    input  p1_data_in, p1_ready, p1_err,
    input  main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
    output main_mem_data_in, main_mem_ready,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one main-memory port between two cache controllers
// Every output is a register loaded from the next-state logic; requests are sampled only in IDLE.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               last_grant, last_grant_n;
  logic               op_write, op_write_n;
  logic               grant_id_q, grant_id_n;
  logic [31:0]        addr_q, addr_n;
  logic [31:0]        wdata_q, wdata_n;
  logic               rd_req_q, rd_req_n;
  logic               wr_req_q, wr_req_n;
  logic [511:0]       p0_line_q, p0_line_n;
  logic [511:0]       p1_line_q, p1_line_n;
  logic               p0_ready_q, p0_ready_n;
  logic               p1_ready_q, p1_ready_n;
  logic               p0_err_q, p0_err_n;
  logic               p1_err_q, p1_err_n;
  logic               busy_q, busy_n;
  logic               p0_pend, p1_pend;
  logic               sel;

  assign p0_pend = bus.p0_read_req | bus.p0_write_req;
  assign p1_pend = bus.p1_read_req | bus.p1_write_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      op_write   <= 1'b0;
      grant_id_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      p0_line_q  <= '0;
      p1_line_q  <= '0;
      p0_ready_q <= 1'b0;
      p1_ready_q <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      op_write   <= op_write_n;
      grant_id_q <= grant_id_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rd_req_q   <= rd_req_n;
      wr_req_q   <= wr_req_n;
      p0_line_q  <= p0_line_n;
      p1_line_q  <= p1_line_n;
      p0_ready_q <= p0_ready_n;
      p1_ready_q <= p1_ready_n;
      p0_err_q   <= p0_err_n;
      p1_err_q   <= p1_err_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    op_write_n   = op_write;
    grant_id_n   = grant_id_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    rd_req_n     = 1'b0;
    wr_req_n     = 1'b0;
    p0_line_n    = p0_line_q;
    p1_line_n    = p1_line_q;
    p0_ready_n   = 1'b0;
    p1_ready_n   = 1'b0;
    p0_err_n     = 1'b0;
    p1_err_n     = 1'b0;
    sel          = 1'b0;

    case (state)
      IDLE: begin
        if (p0_pend | p1_pend) begin
          // On a tie the port that did not win last time goes first
          sel          = (p0_pend & p1_pend) ? ~last_grant : p1_pend;
          addr_n       = sel ? bus.p1_addr : bus.p0_addr;
          wdata_n      = sel ? bus.p1_data_out : bus.p0_data_out;
          op_write_n   = sel ? bus.p1_write_req : bus.p0_write_req;
          rd_req_n     = ~op_write_n;
          wr_req_n     = op_write_n;
          grant_id_n   = sel;
          last_grant_n = sel;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (bus.main_mem_ready) begin
          if (!op_write) begin
            if (grant_id_q) p1_line_n = bus.main_mem_data_in;
            else            p0_line_n = bus.main_mem_data_in;
          end
          p0_ready_n = ~grant_id_q;
          p1_ready_n = grant_id_q;
          state_n    = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          p0_ready_n = ~grant_id_q;
          p1_ready_n = grant_id_q;
          p0_err_n   = ~grant_id_q;
          p1_err_n   = grant_id_q;
          state_n    = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.main_mem_addr      = addr_q;
  assign bus.main_mem_data_out  = wdata_q;
  assign bus.main_mem_read_req  = rd_req_q;
  assign bus.main_mem_write_req = wr_req_q;
  assign bus.p0_data_in         = p0_line_q;
  assign bus.p1_data_in         = p1_line_q;
  assign bus.p0_ready           = p0_ready_q;
  assign bus.p1_ready           = p1_ready_q;
  assign bus.p0_err             = p0_err_q;
  assign bus.p1_err             = p1_err_q;
  assign bus.busy               = busy_q;
  assign bus.grant_id           = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural memory and service-order model
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // op: 0 read, 1 write, 2 read+write asserted together (write expected)
  typedef struct {
    bit          port;
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;
  int mem_latency = 3;
  bit late_ready = 1'b0;
  txn_t q0[$], q1[$], src0[$], src1[$], served_q[$];
  logic [511:0] model_line [2];
  bit model_last = 1'b1;

  function automatic logic [511:0] make_line(input logic [31:0] a);
    logic [511:0] l;
    if (a == 32'h40) l = {64{8'hA5}};
    else for (int i = 0; i < 16; i++) l[i*32 +: 32] = a ^ (32'h1111_1111 * i) ^ 32'hC3C3_0000;
    return l;
  endfunction

  function automatic txn_t mk(input int op, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.port = 1'b0; t.op = op; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic set_req(input bit p, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (!p) begin
      bus.p0_read_req = rd; bus.p0_write_req = wr; bus.p0_addr = a; bus.p0_data_out = d;
    end else begin
      bus.p1_read_req = rd; bus.p1_write_req = wr; bus.p1_addr = a; bus.p1_data_out = d;
    end
  endtask

  // Main-memory model: answers mem_latency cycles after a request, never if mem_latency < 0
  initial begin : mem_model
    bit          mem_out;
    int          mem_cd;
    logic [31:0] ma, md;
    txn_t        t;
    mem_out = 1'b0; mem_cd = 0; ma = '0; md = '0;
    bus.main_mem_ready = 1'b0;
    bus.main_mem_data_in = '0;
    forever begin
      @(negedge clk); #1;
      bus.main_mem_ready = late_ready;
      if (!bus.busy) begin mem_out = 1'b0; mem_cd = 0; end
      if (mem_out && mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          bus.main_mem_ready = 1'b1;
          bus.main_mem_data_in = make_line(ma);
        end
      end
      if (mem_out && bus.busy && !bus.main_mem_read_req && !bus.main_mem_write_req) begin
        vectors++;
        if (bus.main_mem_addr !== ma || bus.main_mem_data_out !== md) begin
          miscompares++;
          $display("FAIL hold_stable addr=%h data=%h required addr=%h data=%h",
                   bus.main_mem_addr, bus.main_mem_data_out, ma, md);
        end
      end
      if (bus.main_mem_read_req || bus.main_mem_write_req) begin
        vectors++;
        if (mem_out || (bus.main_mem_read_req && bus.main_mem_write_req)) begin
          miscompares++;
          $display("FAIL req_pulse rd=%b wr=%b outstanding=%b required one request per transaction",
                   bus.main_mem_read_req, bus.main_mem_write_req, mem_out);
        end
        t.port = bus.grant_id;
        t.op   = bus.main_mem_write_req ? 1 : 0;
        t.addr = bus.main_mem_addr;
        t.data = bus.main_mem_data_out;
        served_q.push_back(t);
        mem_out = 1'b1; mem_cd = mem_latency;
        ma = bus.main_mem_addr; md = bus.main_mem_data_out;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic port_driver(input bit p);
    txn_t t;
    int guard;
    bit rdy, err;
    logic [511:0] din;
    while ((p ? q1.size() : q0.size()) > 0) begin
      if (p) t = q1.pop_front(); else t = q0.pop_front();
      set_req(p, t.op != 1, t.op != 0, t.addr, t.data);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        rdy = p ? bus.p1_ready : bus.p0_ready;
      end while (!rdy && guard < 300);
      din = p ? bus.p1_data_in : bus.p0_data_in;
      err = p ? bus.p1_err : bus.p0_err;
      set_req(p, 1'b0, 1'b0, '0, '0);
      vectors++;
      if (!rdy) begin
        miscompares++;
        $display("FAIL port%0d_ready_timeout ready=0 after %0d cycles required a ready pulse", p, guard);
      end else begin
        if (t.op == 0) model_line[p] = make_line(t.addr);
        if (din !== model_line[p] || err !== 1'b0) begin
          miscompares++;
          $display("FAIL port%0d_resp data_in=%h err=%b required data_in=%h err=0", p, din, err, model_line[p]);
        end
      end
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_fall busy=%b required 0", bus.busy);
      end
    end
  endtask

  // Expected service order: strict alternation while both ports have work, then the remainder
  task automatic run_batch(input string name);
    txn_t exp_q[$];
    txn_t e;
    int i0, i1;
    bit last, pick, ew;
    q0 = src0; q1 = src1;
    served_q.delete();
    fork
      port_driver(1'b0);
      port_driver(1'b1);
    join
    repeat (3) @(negedge clk);
    i0 = 0; i1 = 0; last = model_last;
    while (i0 < src0.size() || i1 < src1.size()) begin
      if (i0 < src0.size() && i1 < src1.size()) pick = ~last;
      else pick = (i0 < src0.size()) ? 1'b0 : 1'b1;
      if (pick) begin e = src1[i1]; i1++; end
      else begin e = src0[i0]; i0++; end
      e.port = pick;
      exp_q.push_back(e);
      last = pick;
    end
    model_last = last;
    vectors++;
    if (served_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count served=%0d required %0d", name, served_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < served_q.size(); k++) begin
      ew = (exp_q[k].op != 0);
      vectors++;
      if (served_q[k].port !== exp_q[k].port || served_q[k].op != (ew ? 1 : 0) ||
          served_q[k].addr !== exp_q[k].addr || (ew && served_q[k].data !== exp_q[k].data)) begin
        miscompares++;
        $display("FAIL %s_order[%0d] port=%0d wr=%0d addr=%h data=%h required port=%0d wr=%0d addr=%h data=%h",
                 name, k, served_q[k].port, served_q[k].op, served_q[k].addr, served_q[k].data,
                 exp_q[k].port, ew, exp_q[k].addr, exp_q[k].data);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_line[0] = '0; model_line[1] = '0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state busy=%b grant_id=%b required 0 0", bus.busy, bus.grant_id);
    end
    vectors++;
    if (bus.main_mem_read_req !== 1'b0 || bus.main_mem_write_req !== 1'b0 ||
        bus.main_mem_addr !== 32'h0 || bus.main_mem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem_side rd=%b wr=%b addr=%h data=%h required all 0",
               bus.main_mem_read_req, bus.main_mem_write_req, bus.main_mem_addr, bus.main_mem_data_out);
    end
    vectors++;
    if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.p0_err !== 1'b0 || bus.p1_err !== 1'b0 ||
        bus.p0_data_in !== 512'h0 || bus.p1_data_in !== 512'h0) begin
      miscompares++;
      $display("FAIL reset_port_side r0=%b r1=%b e0=%b e1=%b required all 0",
               bus.p0_ready, bus.p1_ready, bus.p0_err, bus.p1_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    mem_latency = 5;
    src0.delete(); src1.delete();
    src0.push_back(mk(0, 32'h40, 32'h0));
    run_batch("single_read");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    mem_latency = 4;
    src0.delete(); src1.delete();
    src0.push_back(mk(0, 32'h80, 32'h0));
    src1.push_back(mk(1, 32'h100, 32'hDEADBEEF));
    run_batch("simultaneous");
  endtask

  task automatic test_round_robin();
    mem_latency = 2;
    src0.delete(); src1.delete();
    src0.push_back(mk(0, 32'h1000, 32'h0));
    src0.push_back(mk(0, 32'h1040, 32'h0));
    src1.push_back(mk(0, 32'h2000, 32'h0));
    src1.push_back(mk(0, 32'h2040, 32'h0));
    run_batch("round_robin");
  endtask

  task automatic test_random();
    int n0, n1;
    for (int b = 0; b < 5; b++) begin
      mem_latency = $urandom_range(1, 8);
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      src0.delete(); src1.delete();
      for (int i = 0; i < n0; i++) src0.push_back(mk($urandom_range(0, 2), $urandom() & 32'hFFFF_FFC0, $urandom()));
      for (int i = 0; i < n1; i++) src1.push_back(mk($urandom_range(0, 2), $urandom() & 32'hFFFF_FFC0, $urandom()));
      run_batch("random");
    end
  endtask

  task automatic test_timeout();
    int t_issue, t_ready;
    bit err;
    logic [511:0] din;
    mem_latency = -1;
    t_issue = -1; t_ready = -1; err = 1'b0; din = '0;
    set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int cyc = 0; cyc < 300 && t_ready < 0; cyc++) begin
      @(negedge clk);
      if (bus.main_mem_read_req && t_issue < 0) t_issue = cyc;
      if (bus.p1_ready) begin
        t_ready = cyc; err = bus.p1_err; din = bus.p1_data_in;
      end
    end
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    model_last = 1'b1;
    vectors++;
    if (t_issue < 0 || t_ready < 0 || (t_ready - t_issue) != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL timeout_latency issue=%0d ready=%0d required ready %0d cycles after issue",
               t_issue, t_ready, TIMEOUT + 1);
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err p1_err=%b required 1", err);
    end
    vectors++;
    if (din !== model_line[1]) begin
      miscompares++;
      $display("FAIL timeout_data p1_data_in=%h required %h", din, model_line[1]);
    end
    repeat (2) @(negedge clk);
    late_ready = 1'b1;
    @(negedge clk);
    late_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.main_mem_read_req !== 1'b0) begin
        miscompares++;
        $display("FAIL late_ready_ignored busy=%b r0=%b r1=%b rd=%b required all 0",
                 bus.busy, bus.p0_ready, bus.p1_ready, bus.main_mem_read_req);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit saw_ready;
    int guard;
    saw_ready = 1'b0; guard = 0;
    mem_latency = -1;
    set_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    do begin @(negedge clk); guard++; end while (!bus.main_mem_read_req && guard < 20);
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_wait busy=%b required 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.main_mem_addr, bus.main_mem_data_out, bus.main_mem_read_req, bus.main_mem_write_req,
         bus.p0_data_in, bus.p1_data_in, bus.p0_ready, bus.p0_err, bus.p1_ready, bus.p1_err,
         bus.busy, bus.grant_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait busy=%b grant=%b addr=%h rd=%b r0=%b r1=%b required all outputs 0",
               bus.busy, bus.grant_id, bus.main_mem_addr, bus.main_mem_read_req, bus.p0_ready, bus.p1_ready);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      if (bus.p0_ready || bus.p1_ready) saw_ready = 1'b1;
    end
    vectors++;
    if (saw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_ready saw_ready=%b required 0", saw_ready);
    end
    rst_n = 1'b1;
    model_line[0] = '0; model_line[1] = '0;
    model_last = 1'b1;
    @(negedge clk);
    mem_latency = 3;
    src0.delete(); src1.delete();
    src0.push_back(mk(0, 32'h240, 32'h0));
    src1.push_back(mk(0, 32'h280, 32'h0));
    run_batch("post_reset_tie");
  endtask

  initial begin
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    model_line[0] = '0;
    model_line[1] = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter sharing the single main-memory port between two cache controllers: port 0 (instruction side) and port 1 (data side).
- Each side presents the same read/write-request, address, ready handshake that a cache controller drives toward main memory.
- The arbiter serialises transactions with round-robin fairness and issues exactly one request pulse per transaction to memory.
- It holds address and data stable until memory responds, returns the 512-bit line to the winner, and times out hung transactions.
- It sits between the cache controllers and the main-memory model/controller.

Parameters:
TIMEOUT, 64, cycles in WAIT without main_mem_ready before the transaction is aborted with error
CNT_W, 7, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_read_req  in  1  port 0 line-read request, level, held until p0_ready
p0_write_req  in  1  port 0 word-write request, level, held until p0_ready
p0_addr  in  32  port 0 address
p0_data_out  in  32  port 0 write data
p0_data_in  out  512  line returned to port 0
p0_ready  out  1  one-cycle completion pulse to port 0
p0_err  out  1  valid with p0_ready; 1 = timed out
p1_read_req, p1_write_req, p1_addr, p1_data_out, p1_data_in, p1_ready, p1_err  (same as port 0, for port 1)
main_mem_addr  out  32  address to memory
main_mem_data_out  out  32  write data to memory
main_mem_read_req  out  1  one-cycle read request pulse
main_mem_write_req  out  1  one-cycle write request pulse
main_mem_data_in  in  512  line from memory
main_mem_ready  in  1  one-cycle completion pulse from memory
busy  out  1  1 whenever state != IDLE
grant_id  out  1  port owning the current/last transaction

Behaviour:
Reset:
- All outputs are registered.
- Reset forces state=IDLE, last_grant=1 (port 0 wins first), timeout counter=0, grant_id=0.
- All req, ready and err outputs =0; all data and address outputs =0.
- Reset asserted mid-transaction aborts silently: no ready pulse is issued.

States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Port requests are sampled only in IDLE.
- Per port, pending = read_req | write_req.
- One port pending: grant it.
- Both ports pending: grant the port != last_grant.
- On grant, in the same edge:
  - latch addr into main_mem_addr and data_out into main_mem_data_out;
  - latch op (write wins if a port asserts both; read is dropped and must be re-requested);
  - set grant_id and last_grant;
  - go to ISSUE.

ISSUE:
- Exactly one cycle.
- main_mem_read_req or main_mem_write_req =1 per the latched op.
- Next state WAIT; counter cleared.

WAIT:
- Both memory requests =0; address and data held.
- Counter increments each cycle.
- main_mem_ready=1:
  - capture main_mem_data_in into the granted port's data_in (reads only; writes leave data_in unchanged);
  - err=0; go to RESP.
- Counter reaches TIMEOUT-1 with no ready: err=1, go to RESP.
- A main_mem_ready arriving in any state other than WAIT is ignored.

RESP:
- Exactly one cycle with granted port's ready=1.
- err is valid in this cycle only.
- Next state IDLE.
- Requesters must drop their request in the cycle after ready; the arbiter does not resample until IDLE.

Other rules:
- The non-granted port's request is held pending with no side effects; it is granted in the next IDLE.
- Minimum turnaround for a transaction: sampled at edge E; request pulse in cycle E+1; ready to port 1 cycle after main_mem_ready.
- With a memory that pulses ready 5 cycles after sampling req, port ready arrives 7 cycles after grant.
- p*_data_in holds its value until the next completed read for that port.

Test Plan:
- Single read: p0_read_req, p0_addr=0x40; memory returns line 0xA5..A5 →
  - one-cycle main_mem_read_req with addr 0x40;
  - p0_ready pulse with p0_data_in=0xA5..A5, p0_err=0;
  - busy falls the next cycle.
- Simultaneous requests after reset: p0 read 0x80 and p1 write 0x100 data 0xDEADBEEF →
  - p0 served first;
  - then main_mem_write_req with addr 0x100, data 0xDEADBEEF;
  - p1_ready; grant_id sequence 0,1.
- Round-robin: both ports request continuously for 4 transactions → grant_id alternates 0,1,0,1; no port is served twice in a row.
- Request pulse width: a memory that re-samples req every cycle sees exactly one req per transaction; addr and data are stable through WAIT.
- Timeout: memory never asserts ready →
  - p1_ready=1 and p1_err=1 exactly TIMEOUT+1 cycles after ISSUE;
  - a late main_mem_ready in IDLE is ignored.
- Reset mid-WAIT: assert rst_n=0 → all outputs 0 and busy=0 immediately; no ready pulse; after release, port 0 wins a tie.
